// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver
// Four-digit (parameterisable) multiplexed 7-segment scan driver.
// Digits are shifted in from the right on each load strobe. The buffer is
// time-multiplexed onto a shared segment bus with one-hot active-low digit
// enables. Each slot opens with one ghost-blanking cycle. Leading zeros can
// be suppressed, and non-BCD codes are shown as a dash.

module bcd_scan_driver #(
    parameter int DIGITS   = 4,     // number of display digits, 2..8
    parameter int SCAN_DIV = 1000,  // clock cycles per digit slot, >= 2
    parameter int LZ_BLANK = 1      // 1: blank leading zeros
) (
    input  logic              clk,
    input  logic              rst_syn,   // asynchronous, active-low
    input  logic              load_syn,
    input  logic [3:0]        Din,
    output logic [6:0]        seg,       // {g,f,e,d,c,b,a}, active-high
    output logic [DIGITS-1:0] an,        // active-low, an[0] = rightmost
    output logic [3:0]        ndig
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // 7-segment decode; anything outside 0..9 becomes a dash (segment g)
    function automatic logic [6:0] seg7_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        return pat;
    endfunction

    logic [DIGITS-1:0][3:0] r_d;       // r_d[0] is the rightmost digit
    logic [3:0]             r_ndig;
    logic [PRE_W-1:0]       r_pre;
    logic [IDX_W-1:0]       r_idx;
    logic [6:0]             r_seg;
    logic [DIGITS-1:0]      r_an;

    logic [DIGITS-1:0]      w_tail_zero;   // bit k: d[k..DIGITS-1] all zero
    logic [3:0]             w_digit;
    logic                   w_supp;
    logic                   w_pre_wrap;
    logic [6:0]             w_seg_nxt;
    logic [DIGITS-1:0]      w_an_nxt;

    assign w_pre_wrap = (r_pre == PRE_W'(SCAN_DIV - 1));

    // Digit buffer shift-in and saturating digit counter
    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            r_d    <= {(DIGITS*4){1'b0}};
            r_ndig <= 4'd0;
        end else if (load_syn) begin
            r_d <= {r_d[DIGITS-2:0], Din};
            if (r_ndig != 4'(DIGITS)) begin
                r_ndig <= r_ndig + 4'd1;
            end else begin
                r_ndig <= r_ndig;
            end
        end else begin
            r_d    <= r_d;
            r_ndig <= r_ndig;
        end
    end

    // Prescaler and slot index; the slot advances when the prescaler wraps
    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            r_pre <= {PRE_W{1'b0}};
            r_idx <= {IDX_W{1'b0}};
        end else if (w_pre_wrap) begin
            r_pre <= {PRE_W{1'b0}};
            if (r_idx == IDX_W'(DIGITS - 1)) begin
                r_idx <= {IDX_W{1'b0}};
            end else begin
                r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
            end
        end else begin
            r_pre <= r_pre + {{(PRE_W-1){1'b0}}, 1'b1};
            r_idx <= r_idx;
        end
    end

    // Leading-zero map: a digit is a leading zero if it and all above are 0
    always_comb begin
        w_tail_zero = {DIGITS{1'b0}};
        for (int k = 0; k < DIGITS; k++) begin
            w_tail_zero[k] = ~|(r_d >> (4 * k));
        end
    end

    // Next segment/enable values from the pre-edge scan state and buffer
    always_comb begin
        w_digit = r_d[r_idx];
        w_supp  = (LZ_BLANK != 0) && (r_idx != {IDX_W{1'b0}}) && w_tail_zero[r_idx];
        if (r_pre == {PRE_W{1'b0}}) begin
            w_an_nxt  = {DIGITS{1'b1}};
            w_seg_nxt = 7'h00;
        end else begin
            w_an_nxt = ~({{(DIGITS-1){1'b0}}, 1'b1} << r_idx);
            if (w_supp) begin
                w_seg_nxt = 7'h00;
            end else begin
                w_seg_nxt = seg7_decode(w_digit);
            end
        end
    end

    // Registered display outputs
    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            r_seg <= 7'h00;
            r_an  <= {DIGITS{1'b1}};
        end else begin
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign ndig = r_ndig;

endmodule
